// File: rtl/snn_pkg.sv
`timescale 1ns/1ps
// Shared constants and the frame state encoding for the SNN image loader.
package snn_pkg;

   localparam int         NUM_PIXELS      = 784;
   localparam int         BYTES_PER_IMAGE = 98;
   localparam logic [3:0] RESULT_PAD      = 4'h0;

   typedef enum logic [2:0] {
      ST_LOAD     = 3'd0,
      ST_UNPACK   = 3'd1,
      ST_START    = 3'd2,
      ST_CLASSIFY = 3'd3,
      ST_SEND     = 3'd4,
      ST_TXWAIT   = 3'd5
   } loader_state_t;

endpackage

// File: rtl/byte_unpacker.sv
`timescale 1ns/1ps
// Serialises received bytes LSB-first into a one-bit-per-cycle write stream,
// with a one-entry skid buffer so a byte can arrive while another is unpacking.
module byte_unpacker
   import snn_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       i_enable,
   input  logic       i_stop,
   input  logic       i_rx_rdy,
   input  logic [7:0] i_rx_data,
   output logic       o_we,
   output logic       o_wdata,
   output logic       o_byte_done,
   output logic       o_buf_full,
   output logic       o_overrun_evt
);

   logic       r_active;
   logic [2:0] r_bitcnt;
   logic [7:0] r_shreg;
   logic [7:0] r_buf;
   logic       r_buf_full;

   logic       w_last;
   logic       w_rx;

   always_comb begin
      w_last        = r_active && (r_bitcnt == 3'd7);
      w_rx          = i_rx_rdy && i_enable;
      // On the last bit a full buffer drains, so a new byte there is not lost.
      o_overrun_evt = i_rx_rdy && (!i_enable || (r_active && !w_last && r_buf_full));
      o_we          = r_active;
      o_wdata       = r_shreg[0];
      o_byte_done   = w_last;
      o_buf_full    = r_buf_full;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_active   <= 1'b0;
         r_bitcnt   <= 3'd0;
         r_shreg    <= 8'h00;
         r_buf      <= 8'h00;
         r_buf_full <= 1'b0;
      end else if (!r_active) begin
         r_bitcnt <= 3'd0;
         if (w_rx) begin
            r_shreg  <= i_rx_data;
            r_active <= 1'b1;
         end
      end else if (w_last) begin
         r_bitcnt <= 3'd0;
         if (i_stop) begin
            // Frame complete: anything buffered belongs to no frame and is discarded.
            r_active   <= 1'b0;
            r_buf_full <= 1'b0;
         end else if (r_buf_full) begin
            r_shreg    <= r_buf;
            r_buf_full <= w_rx;
            if (w_rx) begin
               r_buf <= i_rx_data;
            end
         end else if (w_rx) begin
            r_shreg <= i_rx_data;
         end else begin
            r_active <= 1'b0;
         end
      end else begin
         r_shreg  <= {1'b0, r_shreg[7:1]};
         r_bitcnt <= r_bitcnt + 3'd1;
         if (w_rx && !r_buf_full) begin
            r_buf      <= i_rx_data;
            r_buf_full <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/snn_image_loader.sv
`timescale 1ns/1ps
// Frame controller: loads a packed binary image into the image RAM, starts the
// SNN core, and returns the classified digit over the UART transmitter.
module snn_image_loader #(
   parameter int NUM_PIXELS  = snn_pkg::NUM_PIXELS,
   parameter int ADDR_WIDTH  = 10,
   parameter int DIGIT_WIDTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rx_rdy,
   input  logic [7:0]                rx_data,
   output logic                      ram_we,
   output logic [ADDR_WIDTH-1:0]     ram_addr,
   output logic                      ram_wdata,
   output logic                      core_start,
   input  logic                      core_done,
   input  logic [DIGIT_WIDTH-1:0]    core_digit,
   input  logic                      tx_rdy,
   output logic                      tx_start,
   output logic [7:0]                tx_data,
   output logic [7:0]                led,
   output logic                      overrun,
   output snn_pkg::loader_state_t    dbg_state
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_PIXELS - 1);

   snn_pkg::loader_state_t r_state;
   snn_pkg::loader_state_t w_next;

   logic [ADDR_WIDTH-1:0] r_pixel_cnt;
   logic [ADDR_WIDTH-1:0] r_addr_hold;
   logic [7:0]            r_tx_data;
   logic [7:0]            r_led;
   logic                  r_overrun;
   logic                  r_seen_low;

   logic w_we;
   logic w_wdata;
   logic w_byte_done;
   logic w_buf_full;
   logic w_overrun_evt;
   logic w_enable;
   logic w_stop;
   logic w_core_start;
   logic w_tx_start;

   assign w_enable = (r_state == snn_pkg::ST_LOAD) || (r_state == snn_pkg::ST_UNPACK);
   assign w_stop   = (r_pixel_cnt == LAST_ADDR);

   byte_unpacker u_unpacker (
      .clk           (clk),
      .rst           (rst),
      .i_enable      (w_enable),
      .i_stop        (w_stop),
      .i_rx_rdy      (rx_rdy),
      .i_rx_data     (rx_data),
      .o_we          (w_we),
      .o_wdata       (w_wdata),
      .o_byte_done   (w_byte_done),
      .o_buf_full    (w_buf_full),
      .o_overrun_evt (w_overrun_evt)
   );

   always_comb begin
      w_next       = r_state;
      w_core_start = 1'b0;
      w_tx_start   = 1'b0;
      case (r_state)
         snn_pkg::ST_LOAD: begin
            if (rx_rdy) w_next = snn_pkg::ST_UNPACK;
         end
         snn_pkg::ST_UNPACK: begin
            if (w_byte_done) begin
               if (w_stop)                    w_next = snn_pkg::ST_START;
               else if (w_buf_full || rx_rdy) w_next = snn_pkg::ST_UNPACK;
               else                           w_next = snn_pkg::ST_LOAD;
            end
         end
         snn_pkg::ST_START: begin
            w_core_start = 1'b1;
            w_next       = snn_pkg::ST_CLASSIFY;
         end
         snn_pkg::ST_CLASSIFY: begin
            if (core_done) w_next = snn_pkg::ST_SEND;
         end
         snn_pkg::ST_SEND: begin
            if (tx_rdy) begin
               w_tx_start = 1'b1;
               w_next     = snn_pkg::ST_TXWAIT;
            end
         end
         snn_pkg::ST_TXWAIT: begin
            // Return only once uart_tx has taken the byte and gone idle again.
            if (r_seen_low && tx_rdy) w_next = snn_pkg::ST_LOAD;
         end
         default: w_next = snn_pkg::ST_LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= snn_pkg::ST_LOAD;
         r_pixel_cnt <= '0;
         r_addr_hold <= '0;
         r_tx_data   <= 8'h00;
         r_led       <= 8'h00;
         r_overrun   <= 1'b0;
         r_seen_low  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_we) begin
            r_pixel_cnt <= r_pixel_cnt + 1'b1;
            r_addr_hold <= r_pixel_cnt;
         end
         if (w_overrun_evt) begin
            r_overrun <= 1'b1;
         end
         if ((r_state == snn_pkg::ST_CLASSIFY) && core_done) begin
            r_tx_data <= {snn_pkg::RESULT_PAD, core_digit};
            r_led     <= {snn_pkg::RESULT_PAD, core_digit};
         end
         if (r_state == snn_pkg::ST_SEND) begin
            r_seen_low <= 1'b0;
         end else if ((r_state == snn_pkg::ST_TXWAIT) && !tx_rdy) begin
            r_seen_low <= 1'b1;
         end
         if ((r_state == snn_pkg::ST_TXWAIT) && r_seen_low && tx_rdy) begin
            r_pixel_cnt <= '0;
         end
      end
   end

   // The address output keeps showing the last written pixel between writes.
   assign ram_addr   = w_we ? r_pixel_cnt : r_addr_hold;
   assign ram_we     = w_we;
   assign ram_wdata  = w_wdata;
   assign core_start = w_core_start;
   assign tx_start   = w_tx_start;
   assign tx_data    = r_tx_data;
   assign led        = r_led;
   assign overrun    = r_overrun;
   assign dbg_state  = r_state;

endmodule

// File: doc/snn_image_loader.md
Name: snn_image_loader

Overview:
- SNN-side end of the PC image link. The PC sends a 784-pixel binary image as 98 UART bytes, LSB-first within each byte.
- This block unpacks each byte from uart_rx into sequential 1-bit writes to the input image RAM. After the last bit it starts the SNN core, captures the classified digit, and returns it to the PC through uart_tx.
- It sits between uart_rx/uart_tx and the SNN core inside SNN.

Parameters:
- NUM_PIXELS, 784, image bits per frame (0x310).
- ADDR_WIDTH, 10, image RAM address width.
- DIGIT_WIDTH, 4, width of the classification result.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- rx_rdy  input  1  one-cycle pulse: rx_data valid.
- rx_data  input  8  received byte; bit 0 is the lowest pixel address.
- ram_we  output  1  image RAM write enable.
- ram_addr  output  ADDR_WIDTH  image RAM write address.
- ram_wdata  output  1  pixel bit.
- core_start  output  1  one-cycle pulse: image complete, start inference.
- core_done  input  1  one-cycle pulse: core_digit valid.
- core_digit  input  DIGIT_WIDTH  classified digit 0-9.
- tx_rdy  input  1  level: uart_tx idle and able to accept.
- tx_start  output  1  one-cycle pulse to uart_tx.
- tx_data  output  8  result byte {4'h0, digit}.
- led  output  8  last result {4'h0, digit}, held.
- overrun  output  1  sticky error flag.

Behaviour:
- Reset (synchronous, rst=1 at posedge): state LOAD; pixel counter 0; byte buffer empty. Outputs ram_we, core_start, tx_start and overrun = 0; ram_addr = 0; led = 0; tx_data = 0.
- States:
  - LOAD: wait for a byte.
  - UNPACK: 8 cycles.
  - START: 1 cycle.
  - CLASSIFY: wait for core_done.
  - SEND: wait for tx_rdy.
  - TXWAIT: wait for tx_rdy to fall, then rise.
- LOAD: on rx_rdy, latch rx_data into the shift register and go to UNPACK.
- UNPACK, each cycle k = 0..7:
  - ram_we = 1, ram_wdata = shreg[0], ram_addr = pixel counter.
  - Then shift right and increment the counter.
  - First write occurs the cycle after the rx_rdy pulse.
- After bit 7 of a byte:
  - Counter == NUM_PIXELS → START.
  - Pending byte in buffer → UNPACK again with no idle cycle.
  - Otherwise → LOAD.
- Bit budget: NUM_PIXELS is a multiple of 8 (98 × 8 = 784), so no partial byte exists.
- Byte buffer: one-entry skid.
  - rx_rdy during UNPACK stores the byte.
  - rx_rdy while the buffer is already full sets overrun (sticky until rst) and drops the new byte.
  - rx_rdy in START, CLASSIFY, SEND or TXWAIT is dropped and sets overrun.
- START: core_start = 1 for exactly one cycle → CLASSIFY.
- CLASSIFY: on core_done, latch tx_data = led = {4'h0, core_digit} → SEND. core_done in any other state is ignored.
- SEND: when tx_rdy = 1, assert tx_start for one cycle → TXWAIT.
- TXWAIT: wait for tx_rdy to go low and then high again, then reset the pixel counter to 0 → LOAD. The next frame is accepted only after the result has finished transmitting.
- Simultaneous rx_rdy and the last UNPACK cycle: the byte goes to the buffer, and the state goes to UNPACK if the counter is not yet at NUM_PIXELS.
- ram_addr holds its last value when ram_we = 0.
- rst mid-frame: abort immediately; the partial image is discarded and the next byte is written at address 0.

Decomposition:
- Shared package snn_pkg:
  - state enum loader_state_t.
  - constants NUM_PIXELS = 784, BYTES_PER_IMAGE = 98, RESULT_PAD = 4'h0.
- One natural sub-module: byte_unpacker (shift register + 3-bit bit counter + skid buffer, producing the we/wdata stream and a byte_done pulse). The parent owns the frame FSM and the UART/core handshakes.

Test Plan:
- Single byte 8'hA5 with rx_rdy pulse → 8 consecutive writes, addr 0..7, data 1,0,1,0,0,1,0,1; ram_we low afterward; state LOAD.
- Full frame of 98 bytes (ramp pattern), rx_rdy spaced 100 cycles → 784 writes, addr 0..783; core_start a single pulse 1 cycle after the write to 783; no writes after that.
- core_done with core_digit = 7 → tx_data = 8'h07, led = 8'h07. tx_start waits until tx_rdy = 1 and then lasts 1 cycle. After the tx_rdy fall/rise, the next frame's byte is written at addr 0.
- rx_rdy pulses 3 cycles apart (second byte mid-UNPACK) → 16 back-to-back writes with no gap; overrun stays 0. A third pulse while the buffer is full → overrun = 1 and remains 1.
- rst asserted after 40 bytes → outputs reach reset values on the next posedge; the following byte is written at addr 0; core_start does not occur until 98 fresh bytes have been received.
- Byte arriving during CLASSIFY → no RAM write; overrun = 1; the result is still sent normally.
